// File: rtl/simon_pkg.sv
// rtl/simon_pkg.sv - shared types and constants for the SIMON output arbiter
package simon_pkg;

   localparam int N = 32;
   localparam logic [3:0] MODE = 4'h0;

   // Header bit positions
   localparam int INFO_TWO   = 7;
   localparam int INFO_DUMMY = 5;
   localparam int INFO_OUT   = 4;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      PRESENT = 2'd1,
      DRAIN   = 2'd2,
      WAIT2   = 2'd3
   } state_t;

   typedef logic [1:0][N-1:0] block_t;

   // Dummy packets are always single-block, even when the two-block bit is set
   function automatic logic is_two_block(input logic [7:0] info);
      return info[INFO_TWO] && !info[INFO_DUMMY];
   endfunction

endpackage

// File: rtl/simon_rr_pick.sv
// rtl/simon_rr_pick.sv - two-requester round-robin selector
module simon_rr_pick (
   input  logic [1:0] i_req,
   input  logic       i_last,
   output logic       o_valid,
   output logic       o_grant
);

   assign o_valid = |i_req;

   // On a tie the lane that did not win last time is chosen; otherwise the lone requester
   assign o_grant = (i_req == 2'b11) ? ~i_last : i_req[1];

endmodule

// File: rtl/simon_out_arbiter.sv
// rtl/simon_out_arbiter.sv - shares one SIMON output packer between encrypt and decrypt lanes
module simon_out_arbiter
   import simon_pkg::*;
#(
   parameter int         N       = simon_pkg::N,
   parameter logic [3:0] MODE    = simon_pkg::MODE,
   parameter int         TIMEOUT = 255
) (
   input  logic              clk,
   input  logic              nR,
   input  logic              req0,
   input  logic [7:0]        info0,
   input  logic [1:0][N-1:0] data0,
   output logic              ack0,
   input  logic              req1,
   input  logic [7:0]        info1,
   input  logic [1:0][N-1:0] data1,
   output logic              ack1,
   output logic              doneDATA,
   input  logic              readDATA,
   output logic [7:0]        infoOUT,
   output logic [7:0]        countOUT,
   output logic [1:0][N-1:0] outDATA,
   output logic              err
);

   // Timer value on the cycle that raises err, so err lands TIMEOUT cycles into WAIT2
   localparam logic [7:0] TO_LAST = 8'(TIMEOUT - 1);

   state_t            r_state;
   logic              r_last_grant;
   logic              r_lane;
   logic              r_owe;
   logic [7:0]        r_timer;
   logic              r_done;
   logic              r_ack0;
   logic              r_ack1;
   logic              r_err;
   logic [7:0]        r_info;
   logic [7:0]        r_count;
   logic [1:0][N-1:0] r_data;

   logic              w_valid;
   logic              w_grant;
   logic [7:0]        w_sel_info;
   logic [1:0][N-1:0] w_sel_data;
   logic              w_hdr_ok;
   logic              w_lane_req;
   logic [1:0][N-1:0] w_lane_data;
   logic              w_ack_any;

   simon_rr_pick u_pick (
      .i_req   ({req1, req0}),
      .i_last  (r_last_grant),
      .o_valid (w_valid),
      .o_grant (w_grant)
   );

   assign w_sel_info  = w_grant ? info1 : info0;
   assign w_sel_data  = w_grant ? data1 : data0;
   assign w_hdr_ok    = (w_sel_info[3:0] == MODE) && w_sel_info[INFO_OUT];
   assign w_lane_req  = r_lane ? req1 : req0;
   assign w_lane_data = r_lane ? data1 : data0;
   // A lane still shows req in the cycle its ack is high; never serve it twice
   assign w_ack_any   = r_ack0 | r_ack1;

   // Packet sequencer: grant, present, drain, and optional wait for the second block
   always_ff @(posedge clk or negedge nR) begin
      if (!nR) begin
         r_state      <= IDLE;
         r_last_grant <= 1'b1;
         r_lane       <= 1'b0;
         r_owe        <= 1'b0;
         r_timer      <= 8'd0;
         r_done       <= 1'b0;
         r_ack0       <= 1'b0;
         r_ack1       <= 1'b0;
         r_err        <= 1'b0;
         r_info       <= 8'd0;
         r_count      <= 8'd0;
         r_data       <= '0;
      end else begin
         r_ack0 <= 1'b0;
         r_ack1 <= 1'b0;
         r_err  <= 1'b0;
         case (r_state)
            IDLE: begin
               if (w_valid && !w_ack_any) begin
                  if (!w_hdr_ok) begin
                     // Reject: consume the block, flag it, keep round-robin history
                     r_ack0 <= ~w_grant;
                     r_ack1 <= w_grant;
                     r_err  <= 1'b1;
                  end else begin
                     r_info  <= w_sel_info;
                     r_data  <= w_sel_data;
                     r_lane  <= w_grant;
                     r_owe   <= is_two_block(w_sel_info);
                     r_state <= PRESENT;
                  end
               end
            end
            PRESENT: begin
               if (r_done && readDATA) begin
                  r_done  <= 1'b0;
                  r_ack0  <= ~r_lane;
                  r_ack1  <= r_lane;
                  r_state <= DRAIN;
               end else begin
                  r_done <= 1'b1;
               end
            end
            DRAIN: begin
               // Packer must release readDATA so the next doneDATA is a fresh rising edge
               if (!readDATA) begin
                  if (r_owe) begin
                     r_owe   <= 1'b0;
                     r_timer <= 8'd0;
                     r_state <= WAIT2;
                  end else begin
                     r_count      <= r_count + 8'd1;
                     r_last_grant <= r_lane;
                     r_state      <= IDLE;
                  end
               end
            end
            WAIT2: begin
               if (w_lane_req && !w_ack_any) begin
                  r_data  <= w_lane_data;
                  r_state <= PRESENT;
               end else if (r_timer == TO_LAST) begin
                  r_err        <= 1'b1;
                  r_count      <= r_count + 8'd1;
                  r_last_grant <= r_lane;
                  r_state      <= IDLE;
               end else begin
                  r_timer <= r_timer + 8'd1;
               end
            end
            default: r_state <= IDLE;
         endcase
      end
   end

   assign ack0     = r_ack0;
   assign ack1     = r_ack1;
   assign err      = r_err;
   assign doneDATA = r_done;
   assign infoOUT  = r_info;
   assign countOUT = r_count;
   assign outDATA  = r_data;

endmodule

// File: tb/tb_simon_out_arbiter.sv
// tb/tb_simon_out_arbiter.sv - directed self-checking bench for simon_out_arbiter
module tb_simon_out_arbiter;

   logic              clk = 1'b0;
   logic              nR = 1'b0;
   logic              req0 = 1'b0;
   logic [7:0]        info0 = 8'h00;
   logic [1:0][31:0]  data0 = '0;
   logic              ack0;
   logic              req1 = 1'b0;
   logic [7:0]        info1 = 8'h00;
   logic [1:0][31:0]  data1 = '0;
   logic              ack1;
   logic              doneDATA;
   logic              readDATA = 1'b0;
   logic [7:0]        infoOUT;
   logic [7:0]        countOUT;
   logic [1:0][31:0]  outDATA;
   logic              err;

   int tests_run = 0;
   int tests_failed = 0;

   simon_out_arbiter #(.N(32), .MODE(4'h0), .TIMEOUT(255)) dut (
      .clk      (clk),
      .nR       (nR),
      .req0     (req0),
      .info0    (info0),
      .data0    (data0),
      .ack0     (ack0),
      .req1     (req1),
      .info1    (info1),
      .data1    (data1),
      .ack1     (ack1),
      .doneDATA (doneDATA),
      .readDATA (readDATA),
      .infoOUT  (infoOUT),
      .countOUT (countOUT),
      .outDATA  (outDATA),
      .err      (err)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      tests_run++;
      if (got !== exp) begin
         tests_failed++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Wait for doneDATA, take the block, drop the acked lane's req, release readDATA
   task automatic serve(output int lane, output logic [63:0] blk, output logic [7:0] cnt);
      int n = 0;
      while (!doneDATA && n < 20) begin
         tick();
         n++;
      end
      check("serve_done", {63'd0, doneDATA}, 64'd1);
      blk = outDATA;
      cnt = countOUT;
      readDATA = 1'b1;
      tick();
      lane = ack1 ? 1 : (ack0 ? 0 : -1);
      if (ack0) req0 = 1'b0;
      if (ack1) req1 = 1'b0;
      readDATA = 1'b0;
      tick();
   endtask

   int          lane;
   logic [63:0] blk;
   logic [7:0]  cnt;
   int          n;
   logic        seen_done;

   initial begin
      // Reset state
      tick();
      tick();
      check("rst_done", {63'd0, doneDATA}, 64'd0);
      check("rst_count", {56'd0, countOUT}, 64'd0);
      check("rst_info", {56'd0, infoOUT}, 64'd0);
      check("rst_data", outDATA, 64'd0);
      check("rst_err_ack", {61'd0, err, ack0, ack1}, 64'd0);
      nR = 1'b1;
      tick();

      // Single-block packet on lane 0
      info0 = 8'h10;
      data0 = {32'h0000000A, 32'h0000000B};
      req0 = 1'b1;
      tick();
      check("t1_done_lat1", {63'd0, doneDATA}, 64'd0);
      tick();
      check("t1_done_lat2", {63'd0, doneDATA}, 64'd1);
      check("t1_data", outDATA, 64'h0000000A_0000000B);
      check("t1_info", {56'd0, infoOUT}, 64'h10);
      check("t1_count", {56'd0, countOUT}, 64'd0);
      readDATA = 1'b1;
      tick();
      check("t1_ack0", {62'd0, ack0, ack1}, 64'b10);
      check("t1_done_low", {63'd0, doneDATA}, 64'd0);
      req0 = 1'b0;
      readDATA = 1'b0;
      tick();
      check("t1_ack0_pulse", {63'd0, ack0}, 64'd0);
      check("t1_count_inc", {56'd0, countOUT}, 64'd1);

      // Two-block packet on lane 1 with lane 0 arriving mid-packet
      info1 = 8'h90;
      data1 = {32'h0000000C, 32'h0000000D};
      req1 = 1'b1;
      tick();
      info0 = 8'h10;
      data0 = {32'h0000000E, 32'h0000000F};
      req0 = 1'b1;
      serve(lane, blk, cnt);
      check("t2_b1_lane", lane, 64'd1);
      check("t2_b1_data", blk, 64'h0000000C_0000000D);
      check("t2_b1_count", {56'd0, cnt}, 64'd1);
      data1 = {32'h00000001, 32'h00000002};
      req1 = 1'b1;
      serve(lane, blk, cnt);
      check("t2_b2_lane", lane, 64'd1);
      check("t2_b2_data", blk, 64'h00000001_00000002);
      check("t2_b2_count", {56'd0, cnt}, 64'd1);
      check("t2_info", {56'd0, infoOUT}, 64'h90);
      check("t2_count_after", {56'd0, countOUT}, 64'd2);
      serve(lane, blk, cnt);
      check("t2_l0_lane", lane, 64'd0);
      check("t2_l0_data", blk, 64'h0000000E_0000000F);
      check("t2_l0_count", {56'd0, cnt}, 64'd2);
      check("t2_count_final", {56'd0, countOUT}, 64'd3);

      // Contention right after reset: grants alternate 0,1,0
      nR = 1'b0;
      #1;
      check("rst2_count", {56'd0, countOUT}, 64'd0);
      nR = 1'b1;
      tick();
      info0 = 8'h10; data0 = {32'h00000A00, 32'h00000A01};
      info1 = 8'h10; data1 = {32'h00000B00, 32'h00000B01};
      req0 = 1'b1;
      req1 = 1'b1;
      serve(lane, blk, cnt);
      check("t3_g0", lane, 64'd0);
      check("t3_d0", blk, 64'h00000A00_00000A01);
      req0 = 1'b1;
      serve(lane, blk, cnt);
      check("t3_g1", lane, 64'd1);
      check("t3_d1", blk, 64'h00000B00_00000B01);
      req1 = 1'b1;
      serve(lane, blk, cnt);
      check("t3_g2", lane, 64'd0);
      req1 = 1'b0;
      tick();
      check("t3_count", {56'd0, countOUT}, 64'd3);

      // Bad header on lane 0
      info0 = 8'h05;
      req0 = 1'b1;
      tick();
      check("t4_ack_err", {61'd0, ack0, err, doneDATA}, 64'b110);
      req0 = 1'b0;
      tick();
      check("t4_pulse_end", {61'd0, ack0, err, doneDATA}, 64'b000);
      tick();
      check("t4_count", {56'd0, countOUT}, 64'd3);
      check("t4_done", {63'd0, doneDATA}, 64'd0);

      // Second-block timeout on lane 1; lane 0 waits and is served afterwards
      info1 = 8'h90;
      data1 = {32'h00000003, 32'h00000004};
      req1 = 1'b1;
      tick();
      info0 = 8'h10;
      data0 = {32'h00000005, 32'h00000006};
      req0 = 1'b1;
      serve(lane, blk, cnt);
      check("t5_b1_lane", lane, 64'd1);
      n = 0;
      seen_done = 1'b0;
      while (!err && n < 400) begin
         tick();
         n++;
         seen_done |= doneDATA;
      end
      check("t5_timeout_cycles", n, 64'd255);
      check("t5_no_other_lane", {63'd0, seen_done}, 64'd0);
      check("t5_count", {56'd0, countOUT}, 64'd4);
      serve(lane, blk, cnt);
      check("t5_l0_lane", lane, 64'd0);
      check("t5_l0_data", blk, 64'h00000005_00000006);
      check("t5_l0_count", {56'd0, cnt}, 64'd4);
      check("t5_count_final", {56'd0, countOUT}, 64'd5);

      // Count wrap 255 -> 0
      for (int i = 0; i < 250; i++) begin
         req0 = 1'b1;
         serve(lane, blk, cnt);
      end
      check("t6_count_255", {56'd0, countOUT}, 64'd255);
      req0 = 1'b1;
      serve(lane, blk, cnt);
      check("t6_cnt_in_pkt", {56'd0, cnt}, 64'd255);
      check("t6_count_wrap", {56'd0, countOUT}, 64'd0);
      req0 = 1'b1;
      serve(lane, blk, cnt);
      check("t6_count_1", {56'd0, countOUT}, 64'd1);

      // Asynchronous reset during PRESENT
      req0 = 1'b1;
      tick();
      tick();
      check("t7_present", {63'd0, doneDATA}, 64'd1);
      nR = 1'b0;
      #1;
      check("t7_rst_done", {63'd0, doneDATA}, 64'd0);
      check("t7_rst_count", {56'd0, countOUT}, 64'd0);
      check("t7_rst_data", outDATA, 64'd0);
      check("t7_rst_info", {56'd0, infoOUT}, 64'd0);
      nR = 1'b1;
      serve(lane, blk, cnt);
      check("t7_after_lane", lane, 64'd0);
      check("t7_after_count", {56'd0, cnt}, 64'd0);
      check("t7_count_next", {56'd0, countOUT}, 64'd1);

      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule

// File: doc/simon_out_arbiter.md
Name: simon_out_arbiter

Overview:
- Shares one SIMON output packer between two cipher lanes (lane 0 = encrypt engine, lane 1 = decrypt engine).
- Grants the packer round-robin, keeps each packet atomic (one or two blocks), and generates the running packet count.
- Drives the packer's doneDATA/readDATA handshake and validates each packet header before forwarding.

Parameters:
- N, 32: word width; one block is 2 words.
- MODE, 4'h0: expected info[3:0] mode code.
- TIMEOUT, 255: maximum cycles to wait for the second block of a two-block packet; 8-bit range.

Ports:
- clk  in  1  system clock
- nR  in  1  reset; asynchronous, active-low
- req0  in  1  lane 0 has a block ready; level, held until ack0
- info0  in  8  lane 0 header (bit7 two-block packet, bit5 dummy, bit4 output packet, bits3:0 mode)
- data0  in  2xN  lane 0 block words
- ack0  out  1  one-cycle pulse: lane 0 block consumed
- req1/info1/data1/ack1: same as lane 0, for lane 1
- doneDATA  out  1  block presented to packer, level
- readDATA  in  1  packer has taken the block
- infoOUT  out  8  header of current packet
- countOUT  out  8  packet count, stable for the whole packet
- outDATA  out  2xN  current block
- err  out  1  one-cycle pulse: header rejected or second-block timeout

Behaviour:
- Reset (async, mid-operation included): all outputs 0, state IDLE, last_grant=1 (lane 0 wins first tie), timer 0. A packer transfer in flight is abandoned.
- A packet is two blocks if info[7] && !info[5]; otherwise one block.
- IDLE:
  - If one req is high, grant that lane.
  - If both are high, grant the lane != last_grant.
  - If the granted header fails (info[3:0]!=MODE or !info[4]): pulse ack and err, stay IDLE; last_grant is not updated.
  - Otherwise latch info/data into infoOUT/outDATA and go PRESENT next cycle.
- PRESENT: doneDATA=1. When readDATA=1: doneDATA<=0, pulse ack of the granted lane, go DRAIN.
- DRAIN: wait for readDATA=0.
  - If the second block is still owed, go WAIT2 and clear the timer.
  - Otherwise countOUT<=countOUT+1 (mod 256), last_grant<=granted lane, go IDLE.
- WAIT2: only the granted lane is served; the other lane's req is ignored.
  - On granted req: latch that lane's data only (infoOUT unchanged), go PRESENT.
  - If the timer reaches TIMEOUT: pulse err, increment countOUT, update last_grant, go IDLE.
- Latency: req seen in IDLE to doneDATA high is 2 cycles. ack is exactly 1 cycle after readDATA is first sampled high.
- infoOUT, countOUT and outDATA are stable while doneDATA=1. The packer reads on a rising doneDATA, so doneDATA must go low before it is reasserted; DRAIN guarantees this.
- countOUT is never changed mid-packet; the packer checks it on the first block and embeds it on the last.
- Dummy packets (info[5]=1) are forwarded unchanged as single blocks.

Decomposition:
- simon_pkg holds: N, MODE, info bit indices (INFO_TWO=7, INFO_DUMMY=5, INFO_OUT=4), the state enum {IDLE, PRESENT, DRAIN, WAIT2}, and a block typedef (logic [1:0][N-1:0]).
- One sub-module, simon_rr_pick: a two-requester round-robin selector (req, last_grant -> grant), combinational.

Test Plan:
- Single-block packet: lane 0 info=8'h10 (MODE 0), data={32'hA,32'hB} -> doneDATA rises 2 cycles later with outDATA={A,B}, countOUT=0. readDATA pulse -> ack0 pulse, then countOUT=1.
- Two-block packet: lane 1 info=8'h90, two blocks. Lane 0 requests mid-packet -> both lane 1 blocks forwarded back-to-back under one countOUT. Lane 0 is granted only after countOUT increments.
- Contention: both reqs high after reset -> lane 0 granted first, then lane 1, then lane 0. The grant sequence alternates 0,1,0 over 3 packets.
- Bad header: lane 0 info=8'h05 -> err and ack0 pulse, doneDATA stays 0, countOUT unchanged.
- Timeout: lane 1 info=8'h90, first block sent, second never arrives -> err after TIMEOUT cycles, countOUT+1, lane 0 then served.
- Wrap and reset: 256 packets -> countOUT wraps 255->0. Asserting nR low during PRESENT -> all outputs 0 immediately; the next packet starts at countOUT=0.
